tx_uart_logic: RTL and testbench

TX_UART_LOGIC -- requirements
Module: tx_uart_logic

---
 rtl/tx_uart_logic_pkg.sv | 31 +++
 rtl/tx_uart_logic_if.sv | 32 +++
 rtl/tx_uart_logic_csum.sv | 29 ++
 rtl/tx_uart_logic.sv | 160 ++++++++++++++++
 tb/tb_tx_uart_logic.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tx_uart_logic_pkg.sv
// Shared UART packet definitions: FSM states, checksum width and frame field order.
// The receiver side imports the same package so both ends agree on framing.
package tx_uart_logic_pkg;

    localparam int CSUM_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        LEN,
        FETCH,
        DATA,
        CSUM,
        WAIT,
        DONE
    } uart_state_e;

    // Bytes go out on the line in this order: command, length, payload, checksum.
    typedef enum logic [1:0] {
        FIELD_CMD,
        FIELD_LEN,
        FIELD_DATA,
        FIELD_CSUM
    } frame_field_e;

    // States in which exactly one byte is handed to the byte transmitter.
    function automatic logic is_byte_state(uart_state_e s);
        return (s == CMD) || (s == LEN) || (s == DATA) || (s == CSUM);
    endfunction

endpackage

// File: rtl/tx_uart_logic_if.sv
// Byte-transmitter and payload-buffer side of the packet sender.
// master = packet logic, slave = transmitter plus buffer.
interface tx_uart_logic_if
    import tx_uart_logic_pkg::*;
#(
    parameter int NUMBER = 256
);
    localparam int ADDR_W = $clog2(NUMBER);

    logic [ADDR_W-1:0] rd_addr;
    logic [CSUM_W-1:0] rd_data;
    logic [CSUM_W-1:0] tx_data;
    logic              tx_start;
    logic              tx_done;

    modport master (
        output rd_addr,
        output tx_data,
        output tx_start,
        input  rd_data,
        input  tx_done
    );

    modport slave (
        input  rd_addr,
        input  tx_data,
        input  tx_start,
        output rd_data,
        output tx_done
    );

endinterface

// File: rtl/tx_uart_logic_csum.sv
// Packet checksum accumulator shared by transmitter and receiver.
// The sum wraps modulo 2^CSUM_W; result is the inverted running sum.
module uart_pkt_csum
    import tx_uart_logic_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              add,
    input  logic [CSUM_W-1:0] data,
    output logic [CSUM_W-1:0] result
);

    logic [CSUM_W-1:0] sum;

    // Running byte sum; clear starts a new frame and wins over add.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum <= '0;
        end else if (clear) begin
            sum <= '0;
        end else if (add) begin
            sum <= sum + data;
        end
    end

    assign result = ~sum;

endmodule

// File: rtl/tx_uart_logic.sv
// Packet sender: frames cmd, len, payload and checksum onto a byte-level UART
// transmitter, reading the payload from an external synchronous buffer.
module tx_uart_logic
    import tx_uart_logic_pkg::*;
#(
    parameter int NUMBER  = 256,
    parameter int TIMEOUT = 100000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pck_start,
    input  logic [7:0]      cmd_tx,
    input  logic [7:0]      len_tx,
    tx_uart_logic_if.master bus,
    output logic            busy,
    output logic            pck_done,
    output logic            err
);

    localparam int ADDR_W = $clog2(NUMBER);
    localparam int TW     = $clog2(TIMEOUT + 1);

    uart_state_e       state;
    uart_state_e       state_n;
    frame_field_e      last_field;
    frame_field_e      cur_field;
    logic [7:0]        cmd_q;
    logic [7:0]        len_q;
    logic [7:0]        data_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        tx_data_q;
    logic [TW-1:0]     tcnt;
    logic              err_q;
    logic              accept;
    logic              reject;
    logic              timeout_hit;
    logic              len_ok;
    logic [7:0]        cur_byte;
    logic [7:0]        csum_result;

    assign len_ok = ({1'b0, len_tx} <= 9'(NUMBER));

    // Next-state and per-state byte selection; pck_start only counts in IDLE.
    always_comb begin
        state_n     = state;
        accept      = 1'b0;
        reject      = 1'b0;
        timeout_hit = 1'b0;
        cur_byte    = tx_data_q;
        cur_field   = FIELD_CMD;
        case (state)
            IDLE: begin
                if (pck_start) begin
                    if (len_ok) begin
                        accept  = 1'b1;
                        state_n = CMD;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            CMD: begin
                cur_byte  = cmd_q;
                cur_field = FIELD_CMD;
                state_n   = WAIT;
            end
            LEN: begin
                cur_byte  = len_q;
                cur_field = FIELD_LEN;
                state_n   = WAIT;
            end
            FETCH: begin
                state_n = DATA;
            end
            DATA: begin
                cur_byte  = bus.rd_data;
                cur_field = FIELD_DATA;
                state_n   = WAIT;
            end
            CSUM: begin
                cur_byte  = csum_result;
                cur_field = FIELD_CSUM;
                state_n   = WAIT;
            end
            WAIT: begin
                if (bus.tx_done) begin
                    case (last_field)
                        FIELD_CMD:  state_n = LEN;
                        FIELD_LEN:  state_n = (len_q != 8'd0) ? FETCH : CSUM;
                        FIELD_DATA: state_n = (data_cnt == len_q) ? CSUM : FETCH;
                        FIELD_CSUM: state_n = DONE;
                        default:    state_n = IDLE;
                    endcase
                end else if (tcnt == TW'(TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_n     = IDLE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State register plus frame bookkeeping: latched request, address, byte count and timeout.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_field <= FIELD_CMD;
            cmd_q      <= '0;
            len_q      <= '0;
            data_cnt   <= '0;
            addr_q     <= '0;
            tx_data_q  <= '0;
            tcnt       <= '0;
            err_q      <= 1'b0;
        end else begin
            state <= state_n;
            err_q <= reject | timeout_hit;
            tcnt  <= ((state == WAIT) && (state_n == WAIT)) ? tcnt + 1'b1 : '0;
            if (accept) begin
                cmd_q    <= cmd_tx;
                len_q    <= len_tx;
                data_cnt <= '0;
                addr_q   <= '0;
            end
            if (is_byte_state(state)) begin
                tx_data_q  <= cur_byte;
                last_field <= cur_field;
            end
            if (state == DATA) begin
                addr_q   <= addr_q + 1'b1;
                data_cnt <= data_cnt + 8'd1;
            end
            if ((state == WAIT) && (state_n == CSUM)) begin
                addr_q <= '0;
            end
        end
    end

    uart_pkt_csum u_csum (
        .clk    (clk),
        .reset  (reset),
        .clear  (accept),
        .add    (is_byte_state(state) && (state != CSUM)),
        .data   (cur_byte),
        .result (csum_result)
    );

    assign bus.tx_start = is_byte_state(state);
    assign bus.tx_data  = is_byte_state(state) ? cur_byte : tx_data_q;
    assign bus.rd_addr  = addr_q;
    assign busy         = (state != IDLE) && (state != DONE);
    assign pck_done     = (state == DONE);
    assign err          = err_q;

endmodule

// File: tb/tb_tx_uart_logic.sv
// Directed bench for tx_uart_logic: a table of frames with hand-computed
// checksums, plus sequences for timeout, rejection, busy-ignore and reset abort.
module tb_tx_uart_logic;

    localparam int NUMBER  = 16;
    localparam int TIMEOUT = 40;

    typedef struct packed {
        logic [7:0]       cmd;
        logic [7:0]       len;
        logic [15:0][7:0] data;
        logic [7:0]       csum;
    } vec_t;

    logic       clk;
    logic       reset;
    logic       pck_start;
    logic [7:0] cmd_tx;
    logic [7:0] len_tx;
    logic       busy;
    logic       pck_done;
    logic       err;

    tx_uart_logic_if #(.NUMBER(NUMBER)) bus ();

    tx_uart_logic #(.NUMBER(NUMBER), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .pck_start (pck_start),
        .cmd_tx    (cmd_tx),
        .len_tx    (len_tx),
        .bus       (bus),
        .busy      (busy),
        .pck_done  (pck_done),
        .err       (err)
    );

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    vec_t       vecs[5];
    logic [7:0] mem[16];
    logic [7:0] cap_q[$];
    logic [7:0] addr_log[$];
    int         done_cnt = 0;
    int         err_cnt = 0;
    int         err_cyc = 0;
    int         err_busy = 0;
    int         len_cyc = 0;
    int         unstable = 0;
    int         addr_moved = 0;
    int         withhold_idx = -1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous payload buffer: data follows the address by one clock.
    always @(posedge clk) bus.rd_data <= mem[bus.rd_addr];

    // Pulse and address monitor, sampled just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (pck_done) done_cnt++;
        if (err) begin
            err_cnt++;
            err_cyc  = cyc;
            err_busy = int'(busy);
        end
        if (bus.rd_addr != '0) addr_moved = 1;
    end

    // Byte transmitter model: captures each tx_start byte, answers tx_done after a short delay.
    initial begin : responder
        int         idx;
        int         pend;
        int         pend_idx;
        int         wait_cnt;
        logic [7:0] cur_b;
        idx = 0;
        pend = 0;
        pend_idx = 0;
        wait_cnt = 0;
        cur_b = 8'h00;
        bus.tx_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.tx_done = 1'b0;
            if (!reset || !busy) begin
                pend = 0;
                idx  = 0;
            end else begin
                if (pend != 0) begin
                    if (bus.tx_data !== cur_b) unstable++;
                    if (bus.tx_start) unstable++;
                    if (wait_cnt > 0) begin
                        wait_cnt--;
                    end else if (pend_idx != withhold_idx) begin
                        bus.tx_done = 1'b1;
                        pend = 0;
                    end
                end
                if (bus.tx_start) begin
                    cap_q.push_back(bus.tx_data);
                    addr_log.push_back(8'(bus.rd_addr));
                    if (idx == 1) len_cyc = cyc;
                    cur_b    = bus.tx_data;
                    pend     = 1;
                    pend_idx = idx;
                    wait_cnt = idx % 3;
                    idx++;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clearLogs();
        cap_q.delete();
        addr_log.delete();
        done_cnt   = 0;
        err_cnt    = 0;
        err_cyc    = 0;
        err_busy   = 0;
        len_cyc    = 0;
        unstable   = 0;
        addr_moved = 0;
    endtask

    // One-cycle request pulse, launched just after a rising edge.
    task automatic applyStimulus(input logic [7:0] c, input logic [7:0] l);
        pck_start = 1'b1;
        cmd_tx    = c;
        len_tx    = l;
        tick(1);
        pck_start = 1'b0;
    endtask

    task automatic waitIdle(input int budget);
        int k = 0;
        while (busy && k < budget) begin
            tick(1);
            k++;
        end
        checkOutput("frame_end_busy", int'(busy), 0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_tx_start"}, int'(bus.tx_start), 0);
        checkOutput({tag, "_busy"}, int'(busy), 0);
        checkOutput({tag, "_pck_done"}, int'(pck_done), 0);
        checkOutput({tag, "_err"}, int'(err), 0);
        checkOutput({tag, "_rd_addr"}, int'(bus.rd_addr), 0);
        checkOutput({tag, "_tx_data"}, int'(bus.tx_data), 0);
    endtask

    task automatic checkFrame(input vec_t v, input string tag);
        int         n;
        logic [7:0] exp_b;
        n = int'(v.len) + 3;
        checkOutput({tag, "_byte_count"}, cap_q.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i == 0)          exp_b = v.cmd;
            else if (i == 1)     exp_b = v.len;
            else if (i == n - 1) exp_b = v.csum;
            else                 exp_b = v.data[i-2];
            if (i < cap_q.size()) begin
                checkOutput($sformatf("%s_byte%0d", tag, i), int'(cap_q[i]), int'(exp_b));
                if (i >= 2 && i < n - 1)
                    checkOutput($sformatf("%s_addr%0d", tag, i - 2), int'(addr_log[i]), i - 2);
            end
        end
        checkOutput({tag, "_pck_done_cnt"}, done_cnt, 1);
        checkOutput({tag, "_err_cnt"}, err_cnt, 0);
        checkOutput({tag, "_tx_data_stable"}, unstable, 0);
        if (v.len == 8'd0) checkOutput({tag, "_rd_addr_idle"}, addr_moved, 0);
    endtask

    task automatic loadMem(input vec_t v);
        for (int i = 0; i < 16; i++) mem[i] = v.data[i];
    endtask

    task automatic runVector(input int n);
        vec_t v;
        v = vecs[n];
        loadMem(v);
        clearLogs();
        applyStimulus(v.cmd, v.len);
        checkOutput($sformatf("v%0d_first_tx_start", n), int'(bus.tx_start), 1);
        checkOutput($sformatf("v%0d_first_tx_data", n), int'(bus.tx_data), int'(v.cmd));
        checkOutput($sformatf("v%0d_busy_up", n), int'(busy), 1);
        waitIdle(2000);
        tick(2);
        checkFrame(v, $sformatf("v%0d", n));
    endtask

    task automatic fillTable();
        for (int i = 0; i < 5; i++) vecs[i] = '0;
        vecs[0].cmd = 8'h74; vecs[0].len = 8'h03;
        vecs[0].data[0] = 8'h5A; vecs[0].data[1] = 8'h18; vecs[0].data[2] = 8'hF0;
        vecs[0].csum = 8'h26;
        vecs[1].cmd = 8'h01; vecs[1].len = 8'h00;
        vecs[1].csum = 8'hFE;
        vecs[2].cmd = 8'hFF; vecs[2].len = 8'h02;
        vecs[2].data[0] = 8'hFF; vecs[2].data[1] = 8'hFF;
        vecs[2].csum = 8'h00;
        vecs[3].cmd = 8'hA5; vecs[3].len = 8'h04;
        vecs[3].data[0] = 8'h01; vecs[3].data[1] = 8'h02;
        vecs[3].data[2] = 8'h03; vecs[3].data[3] = 8'h04;
        vecs[3].csum = 8'h4C;
        vecs[4].cmd = 8'h00; vecs[4].len = 8'h10;
        for (int i = 0; i < 16; i++) vecs[4].data[i] = 8'(i);
        vecs[4].csum = 8'h77;
    endtask

    // Hard stop in case the design wedges the bench.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before 500us");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        reset     = 1'b0;
        pck_start = 1'b0;
        cmd_tx    = 8'h00;
        len_tx    = 8'h00;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        fillTable();

        tick(3);
        checkResetOutputs("reset");
        reset = 1'b1;
        tick(2);

        for (int n = 0; n < 5; n++) runVector(n);

        // Oversized request: rejected with a single err pulse, never busy.
        clearLogs();
        applyStimulus(8'h55, 8'd17);
        checkOutput("reject_err", int'(err), 1);
        checkOutput("reject_busy", int'(busy), 0);
        checkOutput("reject_tx_start", int'(bus.tx_start), 0);
        tick(4);
        checkOutput("reject_err_cnt", err_cnt, 1);
        checkOutput("reject_bytes", cap_q.size(), 0);
        checkOutput("reject_err_low", int'(err), 0);

        // Transmitter never finishes the len byte: timeout abort.
        clearLogs();
        mem[0] = 8'h44;
        withhold_idx = 1;
        applyStimulus(8'h33, 8'h01);
        waitIdle(500);
        tick(3);
        checkOutput("timeout_err_cnt", err_cnt, 1);
        checkOutput("timeout_err_delay", err_cyc - len_cyc, TIMEOUT + 1);
        checkOutput("timeout_busy_at_err", err_busy, 0);
        checkOutput("timeout_pck_done", done_cnt, 0);
        checkOutput("timeout_bytes", cap_q.size(), 2);
        withhold_idx = -1;

        // Second request mid-frame must not disturb the frame in flight.
        loadMem(vecs[0]);
        clearLogs();
        applyStimulus(vecs[0].cmd, vecs[0].len);
        tick(5);
        applyStimulus(8'h11, 8'h01);
        waitIdle(2000);
        tick(2);
        checkFrame(vecs[0], "midstart");

        // Reset during the first payload byte abandons the frame silently.
        loadMem(vecs[0]);
        clearLogs();
        applyStimulus(vecs[0].cmd, vecs[0].len);
        begin
            int k = 0;
            while (cap_q.size() < 3 && k < 200) begin
                tick(1);
                k++;
            end
        end
        checkOutput("abort_reached_data", int'(cap_q.size() >= 3), 1);
        reset = 1'b0;
        #1;
        checkResetOutputs("abort");
        tick(3);
        checkOutput("abort_pck_done", done_cnt, 0);
        checkOutput("abort_err", err_cnt, 0);
        reset = 1'b1;
        tick(2);
        runVector(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
